flit_injection_arbiter: RTL and testbench

FLIT_INJECTION_ARBITER -- requirements
Module: flit_injection_arbiter

---
 rtl/flit_injection_arbiter_pkg.sv | 19 +
 rtl/flit_injection_arbiter_if.sv | 38 +++
 rtl/flit_injection_arbiter_rr_arbiter.sv | 37 +++
 rtl/flit_injection_arbiter.sv | 141 ++++++++++++++
 tb/tb_flit_injection_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flit_injection_arbiter_pkg.sv
// Shared NoC definitions for the flit injection arbiter: FSM state encoding
// and width helpers derived from per-instance parameters.
package flit_injection_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Counter must be able to hold the full depth value itself, hence depth+1.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int index_width(input int num);
      return (num > 1) ? $clog2(num) : 1;
   endfunction

endpackage

// File: rtl/flit_injection_arbiter_if.sv
// Requester-side handshake and router-side flit bus of the injection arbiter.
// The master drives requests and credits; the slave (the arbiter) drives the rest.
interface flit_injection_arbiter_if #(
   parameter int NUM_INPUTS = 4,
   parameter int FLIT_WIDTH = 128,
   parameter int DEST_WIDTH = 6
);
   import flit_injection_arbiter_pkg::*;

   localparam int IW = index_width(NUM_INPUTS);

   logic [NUM_INPUTS-1:0]                 req_valid;
   logic [NUM_INPUTS-1:0]                 req_ready;
   logic [NUM_INPUTS-1:0][FLIT_WIDTH-1:0] req_data;
   logic [NUM_INPUTS-1:0][DEST_WIDTH-1:0] req_dest;
   logic [NUM_INPUTS-1:0]                 req_is_tail;
   logic [FLIT_WIDTH-1:0]                 data_out;
   logic [DEST_WIDTH-1:0]                 dest_out;
   logic                                  is_tail_out;
   logic                                  send_out;
   logic                                  credit_in;
   logic [IW-1:0]                         grant_id;
   logic                                  busy;
   logic                                  credit_overflow;

   modport master (
      output req_valid, req_data, req_dest, req_is_tail, credit_in,
      input  req_ready, data_out, dest_out, is_tail_out, send_out,
             grant_id, busy, credit_overflow
   );

   modport slave (
      input  req_valid, req_data, req_dest, req_is_tail, credit_in,
      output req_ready, data_out, dest_out, is_tail_out, send_out,
             grant_id, busy, credit_overflow
   );

endinterface

// File: rtl/flit_injection_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr
// (wrapping at NUM_INPUTS) receives a one-hot grant.
module rr_arbiter
   import flit_injection_arbiter_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   localparam int IW         = index_width(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] i_req,
   input  logic [IW-1:0]         i_ptr,
   output logic [NUM_INPUTS-1:0] o_grant
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;
   logic          w_found;

   // One extra bit on the sum so ptr+offset can exceed NUM_INPUTS-1 before wrapping.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NUM_INPUTS)) begin
            w_sum = w_sum - (IW+1)'(NUM_INPUTS);
         end
         w_idx = w_sum[IW-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flit_injection_arbiter.sv
// Wormhole injection arbiter: round-robin choice of packet owner, packet lock
// until tail, credit-based flow control towards one NoC router input port.
module flit_injection_arbiter
   import flit_injection_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS        = 4,
   parameter int FLIT_WIDTH        = 128,
   parameter int DEST_WIDTH        = 6,
   parameter int FLIT_BUFFER_DEPTH = 4
) (
   input logic                    clk,
   input logic                    rst,
   flit_injection_arbiter_if.slave bus
);

   localparam int            IW       = index_width(NUM_INPUTS);
   localparam int            CW       = credit_width(FLIT_BUFFER_DEPTH);
   localparam logic [CW-1:0] FULL     = CW'(FLIT_BUFFER_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUTS - 1);

   arb_state_t            r_state;
   arb_state_t            w_state_next;
   logic [IW-1:0]         r_last_winner;
   logic [IW-1:0]         r_grant_id;
   logic [CW-1:0]         r_credits;
   logic                  r_overflow;
   logic                  r_send;
   logic                  r_tail;
   logic [FLIT_WIDTH-1:0] r_data;
   logic [DEST_WIDTH-1:0] r_dest;

   logic [IW-1:0]         w_ptr;
   logic [IW-1:0]         w_win_idx;
   logic [IW-1:0]         w_sel;
   logic [NUM_INPUTS-1:0] w_arb_grant;
   logic [NUM_INPUTS-1:0] w_owner_onehot;
   logic [NUM_INPUTS-1:0] w_ready;
   logic                  w_credit_ok;
   logic                  w_accept;
   logic                  w_sel_tail;

   assign w_ptr = (r_last_winner == LAST_IDX) ? '0 : r_last_winner + IW'(1);

   rr_arbiter #(
      .NUM_INPUTS(NUM_INPUTS)
   ) u_rr_arbiter (
      .i_req  (bus.req_valid),
      .i_ptr  (w_ptr),
      .o_grant(w_arb_grant)
   );

   always_comb begin
      w_win_idx = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (w_arb_grant[k]) begin
            w_win_idx = IW'(k);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_owner
      assign w_owner_onehot[gi] = (r_grant_id == IW'(gi));
   end

   // Registered count only: a credit arriving this cycle cannot enable a
   // same-cycle accept. Reset also masks ready while rst is held.
   assign w_credit_ok = (r_credits != '0) && !rst;

   always_comb begin
      w_state_next = r_state;
      w_ready      = '0;
      w_sel        = w_win_idx;
      if (r_state == LOCKED) begin
         w_sel = r_grant_id;
         if (w_credit_ok) begin
            w_ready = w_owner_onehot;
         end
      end else if (w_credit_ok) begin
         w_ready = w_arb_grant;
      end
      w_accept   = |(w_ready & bus.req_valid);
      w_sel_tail = bus.req_is_tail[w_sel];
      case (r_state)
         IDLE:    if (w_accept && !w_sel_tail) w_state_next = LOCKED;
         LOCKED:  if (w_accept && w_sel_tail)  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_winner <= LAST_IDX;
         r_grant_id    <= '0;
         r_credits     <= FULL;
         r_overflow    <= 1'b0;
         r_send        <= 1'b0;
         r_tail        <= 1'b0;
         r_data        <= '0;
         r_dest        <= '0;
      end else begin
         r_send <= w_accept;
         if (w_accept) begin
            r_data <= bus.req_data[w_sel];
            r_dest <= bus.req_dest[w_sel];
            r_tail <= w_sel_tail;
            // Only head flits move the round-robin pointer and the owner.
            if (r_state == IDLE) begin
               r_last_winner <= w_sel;
               r_grant_id    <= w_sel;
            end
         end
         if (w_accept && !bus.credit_in) begin
            r_credits <= r_credits - CW'(1);
         end else if (!w_accept && bus.credit_in) begin
            if (r_credits == FULL) begin
               r_overflow <= 1'b1;
            end else begin
               r_credits <= r_credits + CW'(1);
            end
         end
      end
   end

   assign bus.req_ready       = w_ready;
   assign bus.data_out        = r_data;
   assign bus.dest_out        = r_dest;
   assign bus.is_tail_out     = r_tail;
   assign bus.send_out        = r_send;
   assign bus.grant_id        = r_grant_id;
   assign bus.busy            = (r_state == LOCKED);
   assign bus.credit_overflow = r_overflow;

endmodule

// File: tb/tb_flit_injection_arbiter.sv
// Bench for flit_injection_arbiter: directed vector table, hand-written
// credit/reset sequences, then random traffic against a packet-level model.
module tb_flit_injection_arbiter;

   localparam int N     = 4;
   localparam int FW    = 32;
   localparam int DW    = 6;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   flit_injection_arbiter_if #(.NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW)) bus_if ();

   flit_injection_arbiter #(
      .NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] tail;
      logic         credit;
      logic [N-1:0] ready;
      logic         send;
      int           src;
      logic         busy;
   } vec_t;

   vec_t tbl [22];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] t, input logic c);
      bus_if.req_valid   = v;
      bus_if.req_is_tail = t;
      bus_if.credit_in   = c;
   endtask

   task automatic tag_data(input int tag);
      for (int i = 0; i < N; i++) begin
         bus_if.req_data[i] = {8'(8'hA0 + i), 24'(tag)};
         bus_if.req_dest[i] = DW'(i + 1);
      end
   endtask

   task automatic do_reset();
      drive('0, '0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic count_sends(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (bus_if.send_out) cnt++;
      end
   endtask

   task automatic random_phase(input int cycles);
      int m_owner, m_last, m_cred, m_grant, idx, j;
      logic m_ovf, m_send, m_tail, acc, c;
      logic [FW-1:0] m_data;
      logic [DW-1:0] m_dest;
      logic [N-1:0]  v, t, exp_ready;
      logic [FW-1:0] d [N];
      logic [DW-1:0] e [N];
      m_owner = -1; m_last = N - 1; m_cred = DEPTH; m_grant = 0;
      m_ovf = 1'b0; m_send = 1'b0; m_tail = 1'b0; m_data = '0; m_dest = '0;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         v = N'($urandom());
         for (int i = 0; i < N; i++) begin
            t[i] = ($urandom_range(0, 2) == 0);
            d[i] = FW'($urandom());
            e[i] = DW'($urandom());
            bus_if.req_data[i] = d[i];
            bus_if.req_dest[i] = e[i];
         end
         c = (m_cred < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         drive(v, t, c);

         // Who may send: the packet owner if one exists, else the first valid
         // requester after the last head winner; nobody without a credit.
         exp_ready = '0;
         idx = -1;
         if (m_cred > 0) begin
            if (m_owner >= 0) begin
               exp_ready[m_owner] = 1'b1;
               idx = m_owner;
            end else begin
               for (int k = 1; k <= N; k++) begin
                  j = (m_last + k) % N;
                  if (v[j]) begin
                     exp_ready[j] = 1'b1;
                     idx = j;
                     break;
                  end
               end
            end
         end
         acc = (idx >= 0) && v[idx];

         @(negedge clk);
         check("rnd_ready", bus_if.req_ready, exp_ready);

         m_send = acc;
         if (acc) begin
            m_data = d[idx];
            m_dest = e[idx];
            m_tail = t[idx];
            if (m_owner < 0) begin
               m_last  = idx;
               m_grant = idx;
               if (!t[idx]) m_owner = idx;
            end else if (t[idx]) begin
               m_owner = -1;
            end
            $display("tx cycle=%0d src=%0d data=%h dest=%0d tail=%0b credits_before=%0d",
                     cyc, idx, d[idx], e[idx], t[idx], m_cred);
         end
         if (acc && !c) m_cred--;
         else if (!acc && c) begin
            if (m_cred == DEPTH) m_ovf = 1'b1;
            else m_cred++;
         end

         @(posedge clk);
         #1;
         check("rnd_send", bus_if.send_out, m_send);
         check("rnd_data", bus_if.data_out, m_data);
         check("rnd_dest", bus_if.dest_out, m_dest);
         check("rnd_tail", bus_if.is_tail_out, m_tail);
         check("rnd_busy", bus_if.busy, (m_owner >= 0));
         check("rnd_ovf", bus_if.credit_overflow, m_ovf);
         if (m_owner >= 0) check("rnd_grant", bus_if.grant_id, m_grant);
      end
   endtask

   initial begin
      int cnt;

      // valid, tail, credit | ready, send, src, busy
      tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
      tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
      tbl[7]  = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
      tbl[8]  = '{4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
      tbl[9]  = '{4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
      tbl[10] = '{4'b0110, 4'b0110, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
      tbl[11] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
      tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
      tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
      tbl[14] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 0, 1'b1};
      tbl[15] = '{4'b1110, 4'b0000, 1'b0, 4'b0001, 1'b0, 0, 1'b1};
      tbl[16] = '{4'b1110, 4'b1111, 1'b0, 4'b0001, 1'b0, 0, 1'b1};
      tbl[17] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
      tbl[18] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
      tbl[19] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
      tbl[20] = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
      tbl[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};

      // Reset state, with every requester valid to prove ready is masked.
      drive('1, '1, 1'b0);
      tag_data(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", bus_if.req_ready, '0);
      check("rst_send", bus_if.send_out, 1'b0);
      check("rst_busy", bus_if.busy, 1'b0);
      check("rst_grant", bus_if.grant_id, '0);
      check("rst_ovf", bus_if.credit_overflow, 1'b0);
      check("rst_data", bus_if.data_out, '0);
      check("rst_dest", bus_if.dest_out, '0);
      check("rst_tail", bus_if.is_tail_out, 1'b0);
      @(posedge clk);
      #1;
      drive('0, '0, 1'b0);
      rst = 1'b0;

      for (int r = 0; r < 22; r++) begin
         drive(tbl[r].valid, tbl[r].tail, tbl[r].credit);
         tag_data(r);
         @(negedge clk);
         check("tbl_ready", bus_if.req_ready, tbl[r].ready);
         @(posedge clk);
         #1;
         check("tbl_send", bus_if.send_out, tbl[r].send);
         check("tbl_busy", bus_if.busy, tbl[r].busy);
         if (tbl[r].send) begin
            check("tbl_src", bus_if.data_out[31:24], 64'(8'hA0 + tbl[r].src));
            check("tbl_tag", bus_if.data_out[23:0], 64'(r));
            check("tbl_dest", bus_if.dest_out, 64'(tbl[r].src + 1));
            check("tbl_tail", bus_if.is_tail_out, tbl[r].tail[tbl[r].src]);
         end
         if (tbl[r].busy) check("tbl_grant", bus_if.grant_id, 64'(tbl[r].src));
         $display("row %0d valid=%b ready=%b send=%0b busy=%0b", r, tbl[r].valid,
                  bus_if.req_ready, bus_if.send_out, bus_if.busy);
      end

      // Credit exhaustion, then a single returned credit.
      do_reset();
      drive(4'b0001, 4'b0001, 1'b0);
      count_sends(8, cnt);
      check("drain_sends", cnt, 4);
      @(negedge clk);
      check("drain_ready", bus_if.req_ready, '0);
      drive(4'b0001, 4'b0001, 1'b1);
      #1;
      check("credit_same_cycle_ready", bus_if.req_ready, '0);
      @(posedge clk);
      #1;
      drive(4'b0001, 4'b0001, 1'b0);
      @(negedge clk);
      check("credit_next_cycle_ready", bus_if.req_ready, 4'b0001);
      count_sends(6, cnt);
      check("one_more_send", cnt, 1);
      $display("seq credit: refill sends=%0d", cnt);

      // Credit overflow is sticky and the counter saturates at depth.
      do_reset();
      check("ovf_before", bus_if.credit_overflow, 1'b0);
      drive('0, '0, 1'b1);
      @(posedge clk);
      #1;
      drive(4'b0001, 4'b0001, 1'b0);
      check("ovf_set", bus_if.credit_overflow, 1'b1);
      count_sends(8, cnt);
      check("ovf_saturated_sends", cnt, 4);
      check("ovf_sticky", bus_if.credit_overflow, 1'b1);
      do_reset();
      check("ovf_cleared", bus_if.credit_overflow, 1'b0);
      $display("seq overflow: sends after overflow=%0d", cnt);

      // Reset in the middle of a packet.
      drive(4'b0001, 4'b0000, 1'b0);
      tag_data(100);
      @(posedge clk);
      #1;
      check("mid_head_send", bus_if.send_out, 1'b1);
      check("mid_head_busy", bus_if.busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", bus_if.busy, 1'b0);
      check("mid_rst_send", bus_if.send_out, 1'b0);
      check("mid_rst_ready", bus_if.req_ready, '0);
      @(posedge clk);
      #1;
      drive('1, '1, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_winner", bus_if.req_ready, 4'b0001);
      count_sends(8, cnt);
      check("post_rst_credits", cnt, 4);
      $display("seq reset-mid-packet: sends after release=%0d", cnt);

      do_reset();
      random_phase(400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
